// File: rtl/ext_bus_if.sv
// ext_bus_if: serialises one CPU memory/IO transaction into byte beats on an
// 8-bit bidirectional pin bus. Address bytes go LSB first, then one data beat.
// Each beat is a 4-phase req/ack handshake with a synchronised ack and an
// optional per-phase timeout (TIMEOUT_W = 0 disables it).
// Optional feature macro: EXT_BUS_IF_ADDR_SKIP_EN skips upper address bytes
// that match the last completed transaction.
module ext_bus_if #(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_handshake_ack,
    input  logic [7:0]        bus_data_in,
    output logic              bus_handshake_req,
    output logic [1:0]        bus_state,
    output logic [1:0]        bus_byte_idx,
    output logic              bus_io,
    output logic [7:0]        bus_data_out,
    output logic              bus_output_enable,
    input  logic              memory_read,
    input  logic              memory_write,
    input  logic [ADDR_W-1:0] memory_addr,
    input  logic              memory_io,
    input  logic [7:0]        memory_wdata,
    output logic [7:0]        memory_rdata,
    output logic              memory_done,
    output logic              memory_err
);
    localparam int NBYTES = ADDR_W / 8;
    localparam int CW     = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    localparam bit TMO_EN = (TIMEOUT_W > 0);
    // Last waiting cycle before the counter would hit 2^TIMEOUT_W-1.
    localparam logic [CW-1:0] TMO_LAST = CW'((2 ** CW) - 2);

    localparam logic [1:0] BS_ADDR = 2'd0;
    localparam logic [1:0] BS_WR   = 2'd1;
    localparam logic [1:0] BS_RD   = 2'd2;
    localparam logic [1:0] BS_IDLE = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_REL, S_DONE, S_RECOVER} state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     req_q, req_d;
    logic [1:0]               bst_q, bst_d;
    logic [1:0]               bidx_q, bidx_d;
    logic [2:0]               beat_q, beat_d;   // {is_data, addr byte index}
    logic                     io_q, io_d;
    logic                     wr_q, wr_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic [7:0]               dout_q, dout_d;
    logic                     oe_q, oe_d;
    logic [7:0]               rdata_q, rdata_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NBYTES-1:0]        skip_q, skip_d, skip_new;
    logic                     load, abort;
    logic [2:0]               nb;
`ifdef EXT_BUS_IF_ADDR_SKIP_EN
    logic [ADDR_W-1:0]        last_addr_q, last_addr_d;
    logic                     last_io_q, last_io_d;
    logic                     last_vld_q, last_vld_d;
`endif

    wire ack_s = sync_q[SYNC_STAGES-1];
    wire tmo   = TMO_EN && (cnt_q == TMO_LAST);

    // Next beat after address byte cur: next unskipped byte, else the data beat.
    function automatic logic [2:0] next_beat(input logic [1:0] cur, input logic [NBYTES-1:0] skip);
        logic [2:0] r;
        r = 3'b100;
        for (int j = NBYTES - 1; j >= 1; j--)
            if (j > int'(cur) && !skip[j]) r = {1'b0, 2'(j)};
        return r;
    endfunction

    function automatic logic [7:0] byte_of(input logic [ADDR_W-1:0] a, input logic [1:0] idx);
        logic [7:0] r;
        r = a[7:0];
        for (int j = 1; j < NBYTES; j++)
            if (j == int'(idx)) r = a[8*j +: 8];
        return r;
    endfunction

    // Ack synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus_handshake_ack};
    end

    // Next-state and output decode for the handshake FSM
    always_comb begin
        state_d  = state_q;
        req_d    = 1'b0;
        bst_d    = bst_q;
        bidx_d   = bidx_q;
        beat_d   = beat_q;
        io_d     = io_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        skip_d   = skip_q;
        skip_new = '0;
        load     = 1'b0;
        abort    = 1'b0;
        nb       = beat_q;
`ifdef EXT_BUS_IF_ADDR_SKIP_EN
        last_addr_d = last_addr_q;
        last_io_d   = last_io_q;
        last_vld_d  = last_vld_q;
        for (int j = 1; j < NBYTES; j++)
            skip_new[j] = last_vld_q && (memory_io == last_io_q) &&
                          (memory_addr[8*j +: 8] == last_addr_q[8*j +: 8]);
`endif
        case (state_q)
            S_IDLE: begin
                if (memory_read || memory_write) begin
                    addr_d  = memory_addr;
                    io_d    = memory_io;
                    wdata_d = memory_wdata;
                    wr_d    = memory_write;   // write wins when both are set
                    skip_d  = skip_new;
                    load    = 1'b1;
                    nb      = 3'b000;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (ack_s) begin
                    if (beat_q[2] && !wr_q) rdata_d = bus_data_in;
                    cnt_d   = '0;
                    state_d = S_REL;
                end else if (tmo) begin
                    abort = 1'b1;
                end else begin
                    req_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REL: begin
                if (!ack_s) begin
                    if (beat_q[2]) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        bst_d   = BS_IDLE;
                        oe_d    = 1'b0;
                        bidx_d  = 2'd0;
`ifdef EXT_BUS_IF_ADDR_SKIP_EN
                        last_addr_d = addr_q;
                        last_io_d   = io_q;
                        last_vld_d  = 1'b1;
`endif
                    end else begin
                        load    = 1'b1;
                        nb      = next_beat(beat_q[1:0], skip_q);
                        state_d = S_SETUP;
                    end
                end else if (tmo) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:    state_d = S_IDLE;
            S_RECOVER: if (!ack_s) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_RECOVER;
            done_d  = 1'b1;
            err_d   = 1'b1;
            bst_d   = BS_IDLE;
            oe_d    = 1'b0;
            bidx_d  = 2'd0;
`ifdef EXT_BUS_IF_ADDR_SKIP_EN
            last_vld_d = 1'b0;
`endif
        end

        // Beat outputs are loaded on entry to SETUP and held through REL.
        if (load) begin
            beat_d = nb;
            bidx_d = nb[2] ? 2'd0 : nb[1:0];
            oe_d   = !nb[2] || wr_d;
            bst_d  = nb[2] ? (wr_d ? BS_WR : BS_RD) : BS_ADDR;
            dout_d = nb[2] ? (wr_d ? wdata_d : 8'h00) : byte_of(addr_d, nb[1:0]);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            bst_q   <= BS_IDLE;
            bidx_q  <= 2'd0;
            beat_q  <= 3'd0;
            io_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            dout_q  <= 8'h00;
            oe_q    <= 1'b0;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            bst_q   <= bst_d;
            bidx_q  <= bidx_d;
            beat_q  <= beat_d;
            io_q    <= io_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
        end
    end

`ifdef EXT_BUS_IF_ADDR_SKIP_EN
    // Last completed address; reset and errors invalidate it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr_q <= '0;
            last_io_q   <= 1'b0;
            last_vld_q  <= 1'b0;
        end else begin
            last_addr_q <= last_addr_d;
            last_io_q   <= last_io_d;
            last_vld_q  <= last_vld_d;
        end
    end
`endif

    assign bus_handshake_req = req_q;
    assign bus_state         = bst_q;
    assign bus_byte_idx      = bidx_q;
    assign bus_io            = io_q;
    assign bus_data_out      = dout_q;
    assign bus_output_enable = oe_q;
    assign memory_rdata      = rdata_q;
    assign memory_done       = done_q;
    assign memory_err        = err_q;
endmodule

// File: tb/tb_ext_bus_if.sv
// Bench for ext_bus_if: DUT A (16-bit address, 4-bit timeout) and DUT B
// (24-bit address, default timeout), both with a 2-stage ack synchroniser.
module tb_ext_bus_if;
`ifdef EXT_BUS_IF_ADDR_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif
    localparam int BEAT_CYC = 1 + 2 * (2 + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, io = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  wdata = '0, din = '0;
    logic        loop_a = 1'b1, force_a = 1'b0;

    logic       ack_a, req_a, bio_a, oe_a, done_a, err_a;
    logic [1:0] bst_a, bidx_a;
    logic [7:0] dout_a, rdata_a;
    logic       ack_b, req_b, bio_b, oe_b, done_b, err_b;
    logic [1:0] bst_b, bidx_b;
    logic [7:0] dout_b, rdata_b;

    logic       o_req, o_io, o_oe, o_done, o_err;
    logic [1:0] o_bst, o_bidx;
    logic [7:0] o_dout, o_rdata;

    int n_chk = 0, n_fail = 0;

    // Reference model state per DUT
    bit          last_vld[2];
    bit          last_io[2];
    logic [23:0] last_addr[2];
    logic [7:0]  rdata_m[2];

    typedef struct {
        logic [1:0] st;
        logic [1:0] idx;
        logic       oe;
        logic [7:0] data;
        logic       chk_data;
    } beat_t;

    always #5 clk = ~clk;

    assign ack_a = loop_a ? req_a : force_a;
    assign ack_b = req_b;

    ext_bus_if #(.ADDR_W(16), .SYNC_STAGES(2), .TIMEOUT_W(4)) u_a (
        .clk(clk), .rst(rst), .bus_handshake_ack(ack_a), .bus_data_in(din),
        .bus_handshake_req(req_a), .bus_state(bst_a), .bus_byte_idx(bidx_a),
        .bus_io(bio_a), .bus_data_out(dout_a), .bus_output_enable(oe_a),
        .memory_read(rd & ~sel), .memory_write(wr & ~sel), .memory_addr(addr[15:0]),
        .memory_io(io), .memory_wdata(wdata), .memory_rdata(rdata_a),
        .memory_done(done_a), .memory_err(err_a)
    );

    ext_bus_if #(.ADDR_W(24), .SYNC_STAGES(2), .TIMEOUT_W(8)) u_b (
        .clk(clk), .rst(rst), .bus_handshake_ack(ack_b), .bus_data_in(din),
        .bus_handshake_req(req_b), .bus_state(bst_b), .bus_byte_idx(bidx_b),
        .bus_io(bio_b), .bus_data_out(dout_b), .bus_output_enable(oe_b),
        .memory_read(rd & sel), .memory_write(wr & sel), .memory_addr(addr),
        .memory_io(io), .memory_wdata(wdata), .memory_rdata(rdata_b),
        .memory_done(done_b), .memory_err(err_b)
    );

    assign o_req   = sel ? req_b   : req_a;
    assign o_io    = sel ? bio_b   : bio_a;
    assign o_oe    = sel ? oe_b    : oe_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_err   = sel ? err_b   : err_a;
    assign o_bst   = sel ? bst_b   : bst_a;
    assign o_bidx  = sel ? bidx_b  : bidx_a;
    assign o_dout  = sel ? dout_b  : dout_a;
    assign o_rdata = sel ? rdata_b : rdata_a;

    // One full transaction with ack looped back; beats, latency and data vs model
    task automatic do_txn(input bit s, input bit w, input bit i, input logic [23:0] a,
                          input logic [7:0] wd, input logic [7:0] d, input string tag);
        beat_t exp_q[$];
        beat_t e, cur;
        logic [23:0] am;
        int nbytes, n, bi, lat;
        bit seen, prev_req, skip;
        nbytes = s ? 3 : 2;
        am = s ? a : {8'h00, a[15:0]};
        exp_q.push_back('{2'd0, 2'd0, 1'b1, am[7:0], 1'b1});
        for (int j = 1; j < nbytes; j++) begin
            skip = SKIP_EN && last_vld[s] && (last_io[s] == i) &&
                   (last_addr[s][8*j +: 8] == am[8*j +: 8]);
            if (!skip) exp_q.push_back('{2'd0, 2'(j), 1'b1, am[8*j +: 8], 1'b1});
        end
        exp_q.push_back('{w ? 2'd1 : 2'd2, 2'd0, w, wd, w});
        lat = 1 + exp_q.size() * BEAT_CYC;
        cur = '{2'd0, 2'd0, 1'b0, 8'h00, 1'b0};

        @(negedge clk);
        sel = s; io = i; addr = a; wdata = wd; din = d; loop_a = 1'b1;
        rd = !w; wr = w;
        n = 0; bi = 0; seen = 0; prev_req = 0;
        while (!seen && n < 200) begin
            @(posedge clk); @(negedge clk); n++;
            if (o_req && !prev_req) begin
                cur = '{o_bst, o_bidx, o_oe, o_dout, 1'b1};
                n_chk++;
                if (bi >= exp_q.size()) begin
                    n_fail++;
                    $display("FAIL %s extra beat%0d: got st=%0d idx=%0d", tag, bi, o_bst, o_bidx);
                end else begin
                    e = exp_q[bi];
                    if (o_bst !== e.st || o_bidx !== e.idx || o_oe !== e.oe || o_io !== i ||
                        (e.chk_data && o_dout !== e.data)) begin
                        n_fail++;
                        $display("FAIL %s beat%0d: got st=%0d idx=%0d oe=%0b io=%0b d=%02h, want st=%0d idx=%0d oe=%0b io=%0b d=%02h",
                                 tag, bi, o_bst, o_bidx, o_oe, o_io, o_dout, e.st, e.idx, e.oe, i, e.data);
                    end
                end
                bi++;
            end
            if (!o_req && prev_req) begin
                n_chk++;
                if (o_bst !== cur.st || o_bidx !== cur.idx || o_oe !== cur.oe || o_dout !== cur.data) begin
                    n_fail++;
                    $display("FAIL %s stable beat%0d: got st=%0d idx=%0d oe=%0b d=%02h at req fall, want held st=%0d idx=%0d oe=%0b d=%02h",
                             tag, bi - 1, o_bst, o_bidx, o_oe, o_dout, cur.st, cur.idx, cur.oe, cur.data);
                end
            end
            prev_req = o_req;
            if (o_done) seen = 1;
        end
        rd = 1'b0; wr = 1'b0;
        if (!w) rdata_m[s] = d;

        n_chk++;
        if (!seen || n != lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles (done seen=%0b), want %0d", tag, n, seen, lat);
        end
        n_chk++;
        if (bi != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s beat count: got %0d, want %0d", tag, bi, exp_q.size());
        end
        n_chk++;
        if (o_err !== 1'b0 || o_bst !== 2'd3 || o_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done state: got err=%0b st=%0d oe=%0b, want 0/3/0", tag, o_err, o_bst, o_oe);
        end
        n_chk++;
        if (o_rdata !== rdata_m[s]) begin
            n_fail++;
            $display("FAIL %s rdata: got %02h, want %02h", tag, o_rdata, rdata_m[s]);
        end
        last_vld[s] = 1; last_io[s] = i; last_addr[s] = am;

        @(negedge clk);
        n_chk++;
        if (o_done !== 1'b0 || o_bst !== 2'd3 || o_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after done: got done=%0b st=%0d oe=%0b, want 0/3/0", tag, o_done, o_bst, o_oe);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({req_a, bst_a, bidx_a, bio_a, dout_a, oe_a, rdata_a, done_a, err_a} !==
            {1'b0, 2'd3, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset A: got req=%0b st=%0d idx=%0d io=%0b d=%02h oe=%0b rd=%02h done=%0b err=%0b, want 0/3/0/0/00/0/00/0/0",
                     req_a, bst_a, bidx_a, bio_a, dout_a, oe_a, rdata_a, done_a, err_a);
        end
        n_chk++;
        if ({req_b, bst_b, bidx_b, bio_b, dout_b, oe_b, rdata_b, done_b, err_b} !==
            {1'b0, 2'd3, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset B: got req=%0b st=%0d idx=%0d io=%0b d=%02h oe=%0b rd=%02h done=%0b err=%0b, want 0/3/0/0/00/0/00/0/0",
                     req_b, bst_b, bidx_b, bio_b, dout_b, oe_b, rdata_b, done_b, err_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_txn(0, 1, 0, 24'h001234, 8'hA5, 8'h77, "write16");
        do_txn(0, 0, 0, 24'h0000FF, 8'h00, 8'h5C, "read16");
        do_txn(0, 0, 1, 24'h0000FF, 8'h00, 8'hC3, "read16_io");
    endtask

    task automatic test_addr24();
        do_txn(1, 1, 0, 24'hABCDEF, 8'h3C, 8'h00, "write24");
        do_txn(1, 0, 0, 24'h123456, 8'h00, 8'h9E, "read24");
    endtask

    task automatic test_skip();
        do_txn(0, 0, 0, 24'h001234, 8'h00, 8'h11, "skip_first");
        do_txn(0, 0, 0, 24'h001235, 8'h00, 8'h22, "skip_second");
        do_txn(0, 0, 1, 24'h001236, 8'h00, 8'h33, "skip_io_change");
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            bit s, w, i;
            logic [23:0] a;
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            i = ($urandom_range(0, 9) < 7) ? last_io[s] : 1'($urandom_range(0, 1));
            a = 24'($urandom);
            if ($urandom_range(0, 1) == 1) a = {last_addr[s][23:8], a[7:0]};
            if ($urandom_range(0, 3) == 0) a[15:8] = last_addr[s][15:8] ^ 8'h01;
            do_txn(s, w, i, a, 8'($urandom), 8'($urandom), "random");
        end
    endtask

    task automatic test_timeout();
        int n, hi;
        bit seen;
        @(negedge clk);
        sel = 0; loop_a = 0; force_a = 0;
        io = 0; addr = 24'h0000AA; din = ~rdata_m[0]; rd = 1;
        n = 0; hi = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
            if (req_a) hi++;
            if (done_a) seen = 1;
        end
        rd = 0;
        n_chk++;
        if (!seen || n != 17 || hi != 15) begin
            n_fail++;
            $display("FAIL timeout timing: got done at %0d, req high %0d cycles, want 17 and 15", n, hi);
        end
        n_chk++;
        if (err_a !== 1'b1 || req_a !== 1'b0 || bst_a !== 2'd3 || oe_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout flags: got err=%0b req=%0b st=%0d oe=%0b, want 1/0/3/0", err_a, req_a, bst_a, oe_a);
        end
        n_chk++;
        if (rdata_a !== rdata_m[0]) begin
            n_fail++;
            $display("FAIL timeout rdata: got %02h, want unchanged %02h", rdata_a, rdata_m[0]);
        end
        last_vld[0] = 0;
        @(negedge clk);
        n_chk++;
        if (done_a !== 1'b0 || err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout pulse width: got done=%0b err=%0b, want 0/0", done_a, err_a);
        end
        loop_a = 1;
    endtask

    task automatic test_recover();
        int n;
        bit seen, quiet;
        @(negedge clk);
        sel = 0; loop_a = 0; force_a = 1;
        io = 1; addr = 24'h00BEEF; wdata = 8'h5A; wr = 1;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
            if (done_a) seen = 1;
        end
        n_chk++;
        if (!seen || n != 18 || err_a !== 1'b1) begin
            n_fail++;
            $display("FAIL recover timeout: got done at %0d err=%0b, want 18 and 1", n, err_a);
        end
        last_vld[0] = 0;
        quiet = 1;
        repeat (20) begin
            @(posedge clk); @(negedge clk);
            if (req_a || done_a || oe_a || bst_a != 2'd3) quiet = 0;
        end
        n_chk++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL recover hold: got bus activity while ack held high, want none");
        end
        loop_a = 1;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
            if (done_a) seen = 1;
        end
        wr = 0;
        n_chk++;
        if (!seen || n != 3 + 1 + 3 * BEAT_CYC || err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL recover release: got done at %0d err=%0b, want %0d and 0", n, err_a, 3 + 1 + 3 * BEAT_CYC);
        end
        last_vld[0] = 1; last_io[0] = 1; last_addr[0] = 24'h00BEEF;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bit quiet;
        @(negedge clk);
        sel = 0; loop_a = 1; io = 0; addr = 24'h004321; wdata = 8'h66; wr = 1;
        n = 0;
        while (!req_a && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        n_chk++;
        if (!req_a) begin
            n_fail++;
            $display("FAIL reset_mid start: got req=%0b after %0d cycles, want 1", req_a, n);
        end
        rst = 1;
        #1;
        n_chk++;
        if ({req_a, bst_a, oe_a, done_a, rdata_a} !== {1'b0, 2'd3, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid: got req=%0b st=%0d oe=%0b done=%0b rd=%02h, want 0/3/0/0/00",
                     req_a, bst_a, oe_a, done_a, rdata_a);
        end
        wr = 0;
        for (int s = 0; s < 2; s++) begin
            last_vld[s] = 0; rdata_m[s] = 8'h00;
        end
        @(negedge clk);
        rst = 0;
        quiet = 1;
        repeat (6) begin
            @(negedge clk);
            if (req_a || done_a || oe_a || done_b) quiet = 0;
        end
        n_chk++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL reset_mid after: got bus activity or done after reset, want none");
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            last_vld[s] = 0; last_io[s] = 0; last_addr[s] = '0; rdata_m[s] = 8'h00;
        end
        test_reset();
        test_write_read();
        test_addr24();
        test_skip();
        test_random();
        test_timeout();
        test_recover();
        test_reset_mid();
        test_skip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
